// File: rtl/pe_pkg.sv
// Shared PE constants and the feeder state type, common to the PE array and its operand feeders.
package pe_pkg;

    localparam int PE_DW    = 8;
    localparam int PE_ACC_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        STREAM
    } feeder_state_e;

    // Address width for a depth-entry store; a single entry still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pe_feeder_buf.sv
// Tile buffer for pe_feeder: K column vectors of N lanes, one write port and
// an independent combinational read address per lane.
module pe_feeder_buf
    import pe_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = PE_DW,
    parameter int AW = addr_w(K)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [N*DW-1:0] wdata,
    input  logic [N*AW-1:0] raddr,
    output logic [N*DW-1:0] rdata
);

    logic [N*DW-1:0] mem [K];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < K)) begin
            mem[waddr] <= wdata;
        end
    end

    // Lane i reads only its own slice of the addressed beat.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(raddr[i*AW +: AW]) < K) begin
                rdata[i*DW +: DW] = mem[raddr[i*AW +: AW]][i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// West-edge activation feeder: loads a K-beat tile, then replays it with lane i delayed i cycles.
// Optional build macro PE_FEEDER_PERF_EN adds a saturating 16-bit tile_count output.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = PE_DW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            start,
    output logic [N*DW-1:0] out_a,
    output logic [N-1:0]    out_f,
    output logic            busy,
`ifdef PE_FEEDER_PERF_EN
    output logic [15:0]     tile_count,
`endif
    output logic            done
);

    localparam int AW   = addr_w(K);
    localparam int TW   = $clog2(K + N);
    localparam int CW   = $clog2(K + 1);
    localparam int LAST = K + N - 2;

    feeder_state_e   state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [TW-1:0]   t, t_nx;
    logic [TW-1:0]   pos;
    logic            ready_q;
    logic            hs;
    logic            emit;
    logic            last;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [N*AW-1:0] raddr;
    logic [N*DW-1:0] rdata;
    logic [N-1:0]    fire_nx;
    logic [N*DW-1:0] a_nx;

    assign in_ready = ready_q;
    assign hs       = in_valid && ready_q;
    assign busy     = (state != IDLE);

    pe_feeder_buf #(.N(N), .K(K), .DW(DW), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Output registers look one position ahead: the start cycle already
    // registers position 0, and each STREAM cycle with t registers t+1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        t_nx     = t;
        we       = 1'b0;
        waddr    = '0;
        emit     = 1'b0;
        pos      = '0;
        case (state)
            IDLE: begin
                if (hs) begin
                    we       = 1'b1;
                    cnt_nx   = CW'(1);
                    state_nx = (K == 1) ? FULL : LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    we     = 1'b1;
                    waddr  = AW'(cnt);
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CW'(K - 1)) begin
                        state_nx = FULL;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    emit     = 1'b1;
                    t_nx     = '0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                emit = 1'b1;
                pos  = t + 1'b1;
                t_nx = t + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        last = emit && (pos == TW'(LAST));
        if (last) begin
            state_nx = IDLE;
            t_nx     = '0;
            cnt_nx   = '0;
        end
    end

    always_comb begin
        fire_nx = '0;
        raddr   = '0;
        for (int i = 0; i < N; i++) begin
            fire_nx[i]          = emit && (int'(pos) >= i) && (int'(pos) < i + K);
            raddr[i*AW +: AW]   = AW'(int'(pos) - i);
        end
    end

    always_comb begin
        a_nx = '0;
        for (int i = 0; i < N; i++) begin
            if (fire_nx[i]) begin
                a_nx[i*DW +: DW] = rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            t       <= '0;
            ready_q <= 1'b0;
            out_a   <= '0;
            out_f   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            t       <= t_nx;
            ready_q <= (state_nx == IDLE) || (state_nx == LOAD);
            out_a   <= a_nx;
            out_f   <= fire_nx;
            done    <= last;
        end
    end

`ifdef PE_FEEDER_PERF_EN
    // Counted on the edge that raises done, so the count already includes the tile in the done cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tile_count <= '0;
        end else if (last && (tile_count != 16'hFFFF)) begin
            tile_count <= tile_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Directed/randomized bench for pe_feeder (N=4,K=4) plus a degenerate N=1,K=1 instance.
module tb_pe_feeder;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 8;
    localparam int W  = N * DW;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         start;
    logic [W-1:0] out_a;
    logic [N-1:0] out_f;
    logic         busy;
    logic         done;
    logic [15:0]  tile_count;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [7:0]   s_in_data;
    logic         s_start;
    logic [7:0]   s_out_a;
    logic [0:0]   s_out_f;
    logic         s_busy;
    logic         s_done;
    logic [15:0]  s_tile_count;

    logic [W-1:0] tile [K];
    int           checks;
    int           failures;
    int           tiles_done;

    pe_feeder #(.N(N), .K(K), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .start      (start),
        .out_a      (out_a),
        .out_f      (out_f),
        .busy       (busy),
`ifdef PE_FEEDER_PERF_EN
        .tile_count (tile_count),
`endif
        .done       (done)
    );

    pe_feeder #(.N(1), .K(1), .DW(8)) dut_1x1 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .start      (s_start),
        .out_a      (s_out_a),
        .out_f      (s_out_f),
        .busy       (s_busy),
`ifdef PE_FEEDER_PERF_EN
        .tile_count (s_tile_count),
`endif
        .done       (s_done)
    );

`ifndef PE_FEEDER_PERF_EN
    assign tile_count   = '0;
    assign s_tile_count = '0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < K; k++) tile[k] = W'($urandom());
    endtask

    // Offers tile[] beat by beat; counts accepted beats and cycles taken.
    task automatic load_tile(input bit toggle, output int cycles);
        int  acc;
        bit  v;
        bit  hs;
        acc    = 0;
        cycles = 0;
        v      = 1'b1;
        while (acc < K && cycles < 200) begin
            in_valid = toggle ? v : 1'b1;
            in_data  = tile[acc];
            hs       = in_valid && in_ready;
            step();
            if (hs) acc++;
            v = !v;
            cycles++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("load_beats", acc, K);
        chk("full_busy", busy, 1);
        chk("full_ready", in_ready, 0);
        chk("full_no_fire", out_f, 0);
    endtask

    // Reference: at stream position p, lane i carries beat p-i when 0 <= p-i < K.
    task automatic stream_check();
        logic [N-1:0] exp_f;
        logic [W-1:0] exp_a;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p <= K + N - 2; p++) begin
            exp_f = '0;
            exp_a = '0;
            for (int i = 0; i < N; i++) begin
                if (p >= i && p - i < K) begin
                    exp_f[i]          = 1'b1;
                    exp_a[i*DW +: DW] = tile[p-i][i*DW +: DW];
                end
            end
            chk($sformatf("stream_f p%0d", p), out_f, exp_f);
            chk($sformatf("stream_a p%0d", p), out_a, exp_a);
            chk($sformatf("stream_done p%0d", p), done, (p == K + N - 2));
            if (p < K + N - 2) step();
        end
        tiles_done++;
        chk("done_busy", busy, 0);
        chk("done_ready", in_ready, 1);
`ifdef PE_FEEDER_PERF_EN
        chk("tile_count", tile_count, tiles_done);
`endif
    endtask

    task automatic idle_check();
        step();
        chk("idle_f", out_f, 0);
        chk("idle_a", out_a, 0);
        chk("idle_done", done, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    // stimulus + scoreboard
    initial begin
        int cyc;
        checks     = 0;
        failures   = 0;
        tiles_done = 0;
        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        start      = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        s_start    = 1'b0;
        step();
        step();
        chk("rst_ready", in_ready, 0);
        chk("rst_f", out_f, 0);
        chk("rst_a", out_a, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;
        step();
        chk("post_rst_ready", in_ready, 1);

        // basic skew: lane i of beat k = 8'h10*k + i
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++)
                tile[k][i*DW +: DW] = 8'(16 * k + i);
        load_tile(1'b0, cyc);
        stream_check();
        idle_check();

        // ignored start in IDLE and in LOAD
        fill_random();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_idle_f", out_f, 0);
        chk("ign_idle_busy", busy, 0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = tile[k];
            step();
        end
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ign_load_f", out_f, 0);
        chk("ign_load_ready", in_ready, 1);
        for (int k = 2; k < K; k++) begin
            in_valid = 1'b1;
            in_data  = tile[k];
            step();
        end
        in_valid = 1'b0;
        chk("ign_full_busy", busy, 1);
        chk("ign_full_ready", in_ready, 0);
        stream_check();
        idle_check();

        // backpressure: toggled valid, then junk offered while FULL
        fill_random();
        load_tile(1'b1, cyc);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom());
            step();
            chk("bp_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        stream_check();

        // back-to-back: beat 0 of the next tile offered in the done cycle
        fill_random();
        load_tile(1'b0, cyc);
        chk("b2b_cycles", cyc, K);
        stream_check();
        idle_check();

        // randomized tiles with random valid gaps
        for (int r = 0; r < 3; r++) begin
            fill_random();
            load_tile(1'($urandom_range(0, 1)), cyc);
            repeat ($urandom_range(0, 3)) step();
            stream_check();
            idle_check();
        end

        // reset in the middle of a stream
        fill_random();
        load_tile(1'b0, cyc);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();
        tiles_done = 0;
        chk("mid_rst_f", out_f, 0);
        chk("mid_rst_a", out_a, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", done, 0);
        rstn = 1'b1;
        step();
        chk("mid_rel_ready", in_ready, 1);
        fill_random();
        load_tile(1'b0, cyc);
        stream_check();
        idle_check();

        // degenerate N=1, K=1 instance: each stream is a single cycle
        for (int n = 0; n < 3; n++) begin
            logic [7:0] d;
            d = 8'($urandom());
            chk("s_ready", s_in_ready, 1);
            s_in_valid = 1'b1;
            s_in_data  = d;
            step();
            s_in_valid = 1'b0;
            chk("s_full_busy", s_busy, 1);
            chk("s_full_ready", s_in_ready, 0);
            s_start = 1'b1;
            step();
            s_start = 1'b0;
            chk("s_f", s_out_f, 1);
            chk("s_done", s_done, 1);
            chk("s_a", s_out_a, d);
            chk("s_busy_done", s_busy, 0);
`ifdef PE_FEEDER_PERF_EN
            chk("s_tile_count", s_tile_count, n + 1);
`endif
            step();
            chk("s_f_after", s_out_f, 0);
            chk("s_done_after", s_done, 0);
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
